// File: rtl/disp_page_sched.sv
`default_nettype none
// ============================================================================
// Module      : disp_page_sched
// Description : Lets four 16-bit hex pages share one 4-digit 7-segment
//               display. The pages rotate on a dwell timer. An update tick
//               on a page shows that page and holds it for a longer time.
//               A pause level freezes the display on the current page, and
//               a manual tick steps to the next page.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_page_sched #(
    parameter int DWELL = 100_000_000,
    parameter int HOLD  = 200_000_000,
    parameter int TW    = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] page0,
    input  logic [15:0] page1,
    input  logic [15:0] page2,
    input  logic [15:0] page3,
    input  logic [3:0]  upd,
    input  logic        pause,
    input  logic        next_tick,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out,
    output logic [1:0]  sel,
    output logic        holding
);

    // Last timer count before a dwell or hold interval expires
    localparam logic [TW-1:0] c_dwell_last = TW'(DWELL - 1);
    localparam logic [TW-1:0] c_hold_last  = TW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_ROTATE = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_holding;
    logic [1:0]      w_first_upd;
    logic [15:0]     w_page;

    // Lowest-index pending update wins when several pages tick together
    always_comb begin
        w_first_upd = 2'd0;
        if (upd[0])      w_first_upd = 2'd0;
        else if (upd[1]) w_first_upd = 2'd1;
        else if (upd[2]) w_first_upd = 2'd2;
        else if (upd[3]) w_first_upd = 2'd3;
    end

    // Next-state logic. The priority is pause, then update, then manual step, then timer.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_ROTATE: begin
                if (pause) begin
                    w_state_nxt = ST_PAUSED;
                    w_timer_nxt = '0;
                end else if (|upd) begin
                    w_state_nxt = ST_HOLD;
                    w_sel_nxt   = w_first_upd;
                    w_timer_nxt = '0;
                end else if (next_tick || (r_timer == c_dwell_last)) begin
                    w_sel_nxt   = r_sel + 2'd1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_HOLD: begin
                if (pause) begin
                    w_state_nxt = ST_PAUSED;
                    w_timer_nxt = '0;
                end else if (|upd) begin
                    // A repeat tick on the same page restarts the hold interval
                    w_sel_nxt   = w_first_upd;
                    w_timer_nxt = '0;
                end else if (next_tick) begin
                    w_state_nxt = ST_ROTATE;
                    w_sel_nxt   = r_sel + 2'd1;
                    w_timer_nxt = '0;
                end else if (r_timer == c_hold_last) begin
                    w_state_nxt = ST_ROTATE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_PAUSED: begin
                // Updates are dropped here. A manual step still applies on the release cycle.
                w_timer_nxt = '0;
                if (next_tick) w_sel_nxt = r_sel + 2'd1;
                if (!pause)    w_state_nxt = ST_ROTATE;
            end
            default: begin
                w_state_nxt = ST_ROTATE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, page select, timer and hold flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_ROTATE;
            r_sel     <= 2'd0;
            r_timer   <= '0;
            r_holding <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_timer   <= w_timer_nxt;
            r_holding <= (w_state_nxt == ST_HOLD);
        end
    end

    // Page data goes straight through, so a value change shows up in the same cycle
    always_comb begin
        w_page = page0;
        case (r_sel)
            2'd0: w_page = page0;
            2'd1: w_page = page1;
            2'd2: w_page = page2;
            2'd3: w_page = page3;
            default: w_page = page0;
        endcase
    end

    assign hex3    = w_page[15:12];
    assign hex2    = w_page[11:8];
    assign hex1    = w_page[7:4];
    assign hex0    = w_page[3:0];
    assign dp_out  = 4'b0001 << r_sel;
    assign sel     = r_sel;
    assign holding = r_holding;

endmodule
`default_nettype wire

// File: tb/tb_disp_page_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_page_sched
// Description : Directed self-checking bench for disp_page_sched
//               (DWELL=4, HOLD=6, TW=4). Inputs are driven and outputs are
//               sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_page_sched;

    logic        clk;
    logic        reset;
    logic [15:0] page0, page1, page2, page3;
    logic [3:0]  upd;
    logic        pause;
    logic        next_tick;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic [1:0]  sel;
    logic        holding;

    int n_pass  = 0;
    int n_total = 0;

    disp_page_sched #(.DWELL(4), .HOLD(6), .TW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .page0     (page0),
        .page1     (page1),
        .page2     (page2),
        .page3     (page3),
        .upd       (upd),
        .pause     (pause),
        .next_tick (next_tick),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .dp_out    (dp_out),
        .sel       (sel),
        .holding   (holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; upd = 4'b0; next_tick = 1'b0; pause = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; upd = 4'b0; pause = 1'b0; next_tick = 1'b0;
        page0 = 16'h1234; page1 = 16'h5678; page2 = 16'h9ABC; page3 = 16'hDEF0;
        step(); step();

        // Reset state
        check("rst_sel", sel, 0);
        check("rst_hold", holding, 0);
        check("rst_dp", dp_out, 4'b0001);
        check("rst_hex", {hex3, hex2, hex1, hex0}, 16'h1234);
        page0 = 16'hBEEF; #1;
        check("live_hex", {hex3, hex2, hex1, hex0}, 16'hBEEF);
        reset = 1'b0;

        // Free rotation: each page is shown for 4 cycles, then sel wraps to 0
        for (int i = 0; i < 20; i++) begin
            check("rot_sel", sel, (i / 4) % 4);
            check("rot_dp", dp_out, 32'd1 << ((i / 4) % 4));
            step();
        end

        // An update on page 1 while page 3 is shown
        do_reset();
        repeat (12) step();
        check("pre_upd_sel", sel, 3);
        page1 = 16'hA5C3; upd = 4'b0010;
        step(); upd = 4'b0;
        check("upd_sel", sel, 1);
        check("upd_hex", {hex3, hex2, hex1, hex0}, 16'hA5C3);
        check("upd_dp", dp_out, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            check("hold_on", holding, 1);
            step();
        end
        check("hold_off", holding, 0);
        check("hold_off_sel", sel, 1);
        repeat (3) step();
        check("post_hold_sel1", sel, 1);
        step();
        check("post_hold_sel2", sel, 2);

        // Multi-bit update picks the lowest bit; a retick extends the hold
        do_reset();
        upd = 4'b0110;
        step(); upd = 4'b0;
        check("multi_sel", sel, 1);
        check("multi_hold", holding, 1);
        step(); step();
        upd = 4'b0010;
        step(); upd = 4'b0;
        check("retick_hold", holding, 1);
        repeat (5) step();
        check("ext_hold", holding, 1);
        check("ext_sel", sel, 1);
        step();
        check("ext_end", holding, 0);

        // Pause freezes the page; updates are dropped and manual steps still work
        do_reset();
        step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            upd = (i % 3 == 0) ? 4'b1000 : 4'b0;
            step();
            check("pause_sel", sel, 0);
            check("pause_hold", holding, 0);
        end
        upd = 4'b0; next_tick = 1'b1;
        step(); next_tick = 1'b0;
        check("pause_step1", sel, 1);
        step(); next_tick = 1'b1;
        step(); next_tick = 1'b0;
        check("pause_step2", sel, 2);
        for (int i = 0; i < 8; i++) begin
            upd = (i % 3 == 0) ? 4'b1000 : 4'b0;
            step();
            check("pause_sel2", sel, 2);
            check("pause_hold2", holding, 0);
        end
        upd = 4'b0; pause = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("resume_dwell", sel, 2);
            step();
        end
        check("resume_adv", sel, 3);

        // Update beats next_tick; pause beats update; reset in the middle of a hold
        do_reset();
        upd = 4'b0100; next_tick = 1'b1;
        step(); upd = 4'b0; next_tick = 1'b0;
        check("prio_sel", sel, 2);
        check("prio_hold", holding, 1);
        pause = 1'b1; upd = 4'b1000;
        step(); upd = 4'b0;
        check("pu_sel", sel, 2);
        check("pu_hold", holding, 0);
        pause = 1'b0;
        step();
        check("unpause_sel", sel, 2);
        upd = 4'b0100;
        step(); upd = 4'b0;
        check("mid_hold", holding, 1);
        step();
        check("mid_hold_sel", sel, 2);
        reset = 1'b1; upd = 4'b0001; next_tick = 1'b1; pause = 1'b1;
        step();
        reset = 1'b0; upd = 4'b0; next_tick = 1'b0; pause = 1'b0;
        check("mrst_sel", sel, 0);
        check("mrst_hold", holding, 0);
        check("mrst_dp", dp_out, 4'b0001);
        repeat (3) step();
        check("mrst_dwell", sel, 0);
        step();
        check("mrst_adv", sel, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_page_sched.md
Name: disp_page_sched

Overview:
- Shares the single 4-digit time-multiplexed 7-segment display between four 16-bit hex "pages", e.g. raw-bounce count, debounced count, FSM state and error count.
- Auto-rotates pages on a dwell timer.
- A page's one-cycle update tick preempts rotation and holds that page for a longer interval.
- A pause level freezes the current page; a manual advance tick steps pages.
- Sits between the counter/debounce logic and disp_hex_mux, driving its hex3..hex0 and dp_in.

Parameters:
- DWELL, 100_000_000, clock cycles each page is shown during auto-rotation (≥2).
- HOLD, 200_000_000, clock cycles a page is held after its update tick (≥2).
- TW, 28, timer width; must satisfy 2^TW > max(DWELL, HOLD).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- page0  input  16  hex value of page 0 (page1..page3 identical)
- page1  input  16  page 1 value
- page2  input  16  page 2 value
- page3  input  16  page 3 value
- upd  input  4  one-cycle update ticks; bit i = page i changed
- pause  input  1  level; 1 freezes the display on the current page
- next_tick  input  1  one-cycle manual advance (already debounced and edge-detected upstream)
- hex3  output  4  to disp_hex_mux hex3 (selected page [15:12])
- hex2  output  4  selected page [11:8]
- hex1  output  4  selected page [7:4]
- hex0  output  4  selected page [3:0]
- dp_out  output  4  page indicator to dp_in; bit sel = 1, others 0
- sel  output  2  current page index (registered)
- holding  output  1  1 while in HOLD state (registered)

Behaviour:
- Single clk domain. All state updates on posedge clk. Reset is synchronous, active-high.
- Reset values: state=ROTATE, sel=0, timer=0, holding=0. hex3..hex0 then equal page0 nibbles; dp_out=4'b0001.
- hex3..hex0 and dp_out are combinational functions of the registered sel.
  - Page value changes appear the same cycle; page switches appear one cycle after the causing event.
- Per-cycle priority: reset > pause > upd > next_tick > timer expiry.
- "first(upd)" = lowest-index set bit of upd.
- ROTATE:
  - pause=1 → PAUSED, timer=0, sel unchanged.
  - Else upd≠0 → HOLD, sel=first(upd), timer=0.
  - Else next_tick → sel=sel+1 mod 4, timer=0.
  - Else timer==DWELL-1 → sel=sel+1 mod 4 (3 wraps to 0), timer=0.
  - Else timer+1.
- HOLD (holding=1):
  - pause=1 → PAUSED, timer=0.
  - Else upd≠0 → stay HOLD, sel=first(upd), timer=0. This covers a same-page retick, which extends the hold.
  - Else next_tick → ROTATE, sel=sel+1 mod 4, timer=0.
  - Else timer==HOLD-1 → ROTATE, sel unchanged, timer=0.
  - Else timer+1.
- PAUSED:
  - Timer stays 0; upd ignored (lost, not queued).
  - next_tick → sel=sel+1 mod 4.
  - pause=0 → ROTATE, timer=0. A next_tick in the same cycle still advances sel.
- Timings:
  - Page shown in ROTATE with no events persists exactly DWELL cycles.
  - HOLD persists exactly HOLD cycles after the last upd.
- Timer never exceeds max(DWELL,HOLD)-1; no wrap of the TW-bit counter is permitted.
- Reset mid-HOLD or mid-PAUSED returns to ROTATE, sel=0 in the next cycle regardless of other inputs.

Test Plan (DWELL=4, HOLD=6, TW=4):
- Reset 2 cycles, no inputs → sel=0 for 4 cycles, then 1,2,3, then 0 (wrap), each 4 cycles; dp_out follows 0001,0010,0100,1000.
- page1=16'hA5C3, upd=4'b0010 pulse while sel=3 → next cycle sel=1, holding=1, hex3..0=A,5,C,3. Held 6 cycles, then holding=0; rotation resumes with sel=1 for 4 cycles, then sel=2.
- upd=4'b0110 pulse → sel=1 (lowest bit). Same upd bit 1 pulsed again 3 cycles later → hold extends to 6 cycles from the second pulse.
- pause=1 for 20 cycles with upd=4'b1000 pulses → sel frozen. Two next_tick pulses → sel+2. Release → ROTATE, full 4-cycle dwell before next advance.
- upd and next_tick same cycle in ROTATE → upd wins (HOLD on first(upd)). pause+upd same cycle → PAUSED, sel unchanged.
- Reset asserted mid-HOLD (sel=2) → next cycle sel=0, holding=0, dp_out=0001, timer restarts full dwell.
